ahb_si_arbiter: RTL

AHB_SI_ARBITER -- requirements
Module: ahb_si_arbiter

---
 rtl/ahb_si_arbiter_if.sv | 40 ++++
 rtl/ahb_si_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ahb_si_arbiter_if.sv
// Bundle of the request/lock inputs and the select/owner outputs of one
// AHB slave-port arbiter. The arbiter connects through the slave modport;
// the logic that issues requests and consumes the selects uses master.
interface ahb_si_arbiter_if #(
    parameter int CHANNEL_NUM = 7
);
    localparam int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    logic [CHANNEL_NUM-1:0] hbusreq;
    logic [CHANNEL_NUM-1:0] hlock;
    logic [1:0]             htrans_cur;
    logic                   hready;

    logic [CHANNEL_NUM-1:0] addr_sel;
    logic [CHANNEL_NUM-1:0] data_sel;
    logic [IDX_W-1:0]       hmaster;
    logic                   hmastlock;

    modport slave (
        input  hbusreq,
        input  hlock,
        input  htrans_cur,
        input  hready,
        output addr_sel,
        output data_sel,
        output hmaster,
        output hmastlock
    );

    modport master (
        output hbusreq,
        output hlock,
        output htrans_cur,
        output hready,
        input  addr_sel,
        input  data_sel,
        input  hmaster,
        input  hmastlock
    );
endinterface

// File: rtl/ahb_si_arbiter.sv
// Round-robin arbiter for one AHB slave port. Grants one master at a time
// (one-hot addr_sel), tracks the data-phase owner (data_sel), caps an
// unlocked tenure at MAX_HOLD accepted transfers and holds the bus for a
// locked sequence. Everything freezes while the slave stretches hready.
module ahb_si_arbiter #(
    parameter int CHANNEL_NUM = 7,
    parameter int MAX_HOLD    = 16
) (
    input logic              hclk,
    input logic              hreset,
    ahb_si_arbiter_if.slave  bus
);

    localparam int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OWNED  = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    state_t                 state;
    logic [CHANNEL_NUM-1:0] addr_sel_q;
    logic [CHANNEL_NUM-1:0] data_sel_q;
    logic [IDX_W-1:0]       hmaster_q;
    logic                   hmastlock_q;
    logic [CNT_W-1:0]       hold_cnt;
    logic [IDX_W-1:0]       last_grant;

    logic                   rr_found;
    logic [IDX_W-1:0]       rr_winner;
    logic [IDX_W-1:0]       rr_cand;
    logic [CHANNEL_NUM-1:0] win_onehot;

    logic                   trans_active;
    logic                   trans_may_release;
    logic                   owner_lock;
    logic                   owner_req;
    logic                   hold_done;
    logic                   release_ok;

    // Round-robin search: walk from last_grant+1 upward with wrap, first
    // requester wins. The previous owner is visited last, so it only wins
    // again when nobody else is asking.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_cand   = last_grant;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            rr_cand = (rr_cand == IDX_W'(CHANNEL_NUM - 1)) ? '0 : rr_cand + IDX_W'(1);
            if (!rr_found && bus.hbusreq[rr_cand]) begin
                rr_found  = 1'b1;
                rr_winner = rr_cand;
            end
        end
    end

    // One-hot form of the winner, loaded straight into addr_sel on a grant.
    always_comb begin
        win_onehot            = '0;
        win_onehot[rr_winner] = 1'b1;
    end

    // Tenure bookkeeping. A tenure may end only between bursts (IDLE or a
    // fresh NONSEQ), never on SEQ/BUSY, and only once the owner has either
    // stopped asking or used up its transfer budget.
    always_comb begin
        trans_active      = (bus.htrans_cur == HTRANS_NONSEQ) ||
                            (bus.htrans_cur == HTRANS_SEQ);
        trans_may_release = !((bus.htrans_cur == HTRANS_BUSY) ||
                              (bus.htrans_cur == HTRANS_SEQ));
        owner_lock        = bus.hlock[hmaster_q];
        owner_req         = bus.hbusreq[hmaster_q];
        hold_done         = (hold_cnt >= CNT_W'(MAX_HOLD));
        release_ok        = !owner_lock && trans_may_release &&
                            (!owner_req || hold_done);
    end

    // Arbitration FSM with registered selects. A stretched data phase
    // (hready=0) freezes every register; reset wins regardless and drops any
    // outstanding data phase on the floor.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state       <= ST_IDLE;
            addr_sel_q  <= '0;
            data_sel_q  <= '0;
            hmaster_q   <= '0;
            hmastlock_q <= 1'b0;
            hold_cnt    <= '0;
            last_grant  <= IDX_W'(CHANNEL_NUM - 1);
        end else if (bus.hready) begin
            data_sel_q <= trans_active ? addr_sel_q : '0;
            case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        state       <= ST_OWNED;
                        addr_sel_q  <= win_onehot;
                        hmaster_q   <= rr_winner;
                        last_grant  <= rr_winner;
                        hmastlock_q <= 1'b0;
                        hold_cnt    <= '0;
                    end
                end
                ST_OWNED, ST_LOCKED: begin
                    if (owner_lock) begin
                        state       <= ST_LOCKED;
                        hmastlock_q <= 1'b1;
                        if (trans_active && !hold_done) begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end else if (release_ok) begin
                        if (rr_found) begin
                            state       <= ST_OWNED;
                            addr_sel_q  <= win_onehot;
                            hmaster_q   <= rr_winner;
                            last_grant  <= rr_winner;
                            hmastlock_q <= 1'b0;
                            hold_cnt    <= '0;
                        end else begin
                            state       <= ST_IDLE;
                            addr_sel_q  <= '0;
                            hmaster_q   <= '0;
                            hmastlock_q <= 1'b0;
                            hold_cnt    <= '0;
                        end
                    end else begin
                        state       <= ST_OWNED;
                        hmastlock_q <= 1'b0;
                        if (trans_active && !hold_done) begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    addr_sel_q  <= '0;
                    hmaster_q   <= '0;
                    hmastlock_q <= 1'b0;
                    hold_cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.addr_sel  = addr_sel_q;
    assign bus.data_sel  = data_sel_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

endmodule
